// File: rtl/ex_stage.sv
// RV32I execute stage: forwarding, ALU, branch/jump resolution, cycle/instret counters, EX/MEM register.
// Optional macro EX_CSR_WRITE_EN enables CSR RW/RS/RC writes into the counter halves.
module ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            DM_busy,
    input  logic            id_ex_alusrc,
    input  logic            id_ex_memread,
    input  logic            id_ex_memwrite,
    input  logic            id_ex_regwrite,
    input  logic            id_ex_memtoreg,
    input  logic            id_ex_csr,
    input  logic            id_ex_inst_add1,
    input  logic            id_ex_pctoreg_ctrl,
    input  logic [1:0]      id_ex_jump,
    input  logic [1:0]      id_ex_aluop,
    input  logic [1:0]      id_ex_csr_ctrl,
    input  logic [2:0]      id_ex_funct3,
    input  logic [4:0]      id_ex_funct7_3,
    input  logic [4:0]      id_ex_rd,
    input  logic [XLEN-1:0] id_ex_rs1_data,
    input  logic [XLEN-1:0] id_ex_rs2_data,
    input  logic [XLEN-1:0] id_ex_imm32,
    input  logic [XLEN-1:0] id_ex_pc,
    input  logic [XLEN-1:0] id_ex_pctoreg,
    input  logic [1:0]      fwd_a,
    input  logic [1:0]      fwd_b,
    input  logic [XLEN-1:0] wb_data,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] ex_mem_alu_result,
    output logic [XLEN-1:0] ex_mem_store_data,
    output logic [4:0]      ex_mem_rd,
    output logic [2:0]      ex_mem_funct3,
    output logic            ex_mem_regwrite,
    output logic            ex_mem_memread,
    output logic            ex_mem_memwrite,
    output logic            ex_mem_memtoreg
);
    logic [XLEN-1:0]  op_a, rs2_fwd, op_b, alu_res, csr_val, result, jalr_sum;
    logic [4:0]       shamt;
    logic             alt, taken, eq, lt, ltu;
    logic [CNT_W-1:0] cycle_reg, cycle_next, instret_reg, instret_next;
    logic             retire;
    logic             unused_ok;

    assign unused_ok = ^{id_ex_funct7_3[4], id_ex_funct7_3[2:0]};

    always_comb begin
        case (fwd_a)
            2'b01:   op_a = ex_mem_alu_result;
            2'b10:   op_a = wb_data;
            default: op_a = id_ex_rs1_data;
        endcase
        case (fwd_b)
            2'b01:   rs2_fwd = ex_mem_alu_result;
            2'b10:   rs2_fwd = wb_data;
            default: rs2_fwd = id_ex_rs2_data;
        endcase
    end

    assign op_b  = id_ex_alusrc ? id_ex_imm32 : rs2_fwd;
    assign shamt = op_b[4:0];
    // Immediate forms only honour bit 30 for SRAI, so ADDI never becomes a subtract.
    assign alt   = id_ex_funct7_3[3] & (~id_ex_aluop[0] | (id_ex_funct3 == 3'b101));

    always_comb begin
        alu_res = op_a + op_b;
        if (id_ex_aluop[1]) begin
            case (id_ex_funct3)
                3'b000:  alu_res = alt ? (op_a - op_b) : (op_a + op_b);
                3'b001:  alu_res = op_a << shamt;
                3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
                3'b011:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
                3'b100:  alu_res = op_a ^ op_b;
                3'b101:  alu_res = alt ? $unsigned($signed(op_a) >>> shamt) : (op_a >> shamt);
                3'b110:  alu_res = op_a | op_b;
                default: alu_res = op_a & op_b;
            endcase
        end
    end

    assign eq  = (op_a == rs2_fwd);
    assign lt  = ($signed(op_a) < $signed(rs2_fwd));
    assign ltu = (op_a < rs2_fwd);

    always_comb begin
        case (id_ex_funct3)
            3'b000:  taken = eq;
            3'b001:  taken = ~eq;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: taken = 1'b0;
        endcase
    end

    assign jalr_sum    = op_a + id_ex_imm32;
    assign redirect_pc = (id_ex_jump == 2'b11) ? (jalr_sum & ~{{(XLEN-1){1'b0}}, 1'b1})
                                               : (id_ex_pc + id_ex_imm32);
    // Gated by DM_busy so a stalled jump redirects only in the cycle it leaves EX.
    assign redirect    = (id_ex_jump[1] | ((id_ex_jump == 2'b01) & taken)) & ~DM_busy;

    always_comb begin
        case (id_ex_csr_ctrl)
            2'b00:   csr_val = cycle_reg[31:0];
            2'b01:   csr_val = cycle_reg[63:32];
            2'b10:   csr_val = instret_reg[31:0];
            default: csr_val = instret_reg[63:32];
        endcase
        if (id_ex_csr)
            result = csr_val;
        else if (id_ex_pctoreg_ctrl)
            result = id_ex_pctoreg;
        else
            result = alu_res;
    end

    assign retire = id_ex_inst_add1 & ~DM_busy;

`ifdef EX_CSR_WRITE_EN
    logic            csr_we;
    logic [XLEN-1:0] csr_wval;

    assign csr_we = id_ex_csr & ~DM_busy & (id_ex_funct3[2] == 1'b0) & (id_ex_funct3[1:0] != 2'b00);

    always_comb begin
        case (id_ex_funct3[1:0])
            2'b01:   csr_wval = op_a;
            2'b10:   csr_wval = csr_val | op_a;
            default: csr_wval = csr_val & ~op_a;
        endcase
        cycle_next   = cycle_reg + CNT_W'(1);
        instret_next = instret_reg + CNT_W'(retire);
        // The written half replaces the increment; the other half sees no carry from it.
        if (csr_we) begin
            case (id_ex_csr_ctrl)
                2'b00:   cycle_next   = {cycle_reg[63:32], csr_wval};
                2'b01:   cycle_next   = {csr_wval, cycle_reg[31:0] + 32'd1};
                2'b10:   instret_next = {instret_reg[63:32], csr_wval};
                default: instret_next = {csr_wval, instret_reg[31:0] + {31'd0, retire}};
            endcase
        end
    end
`else
    always_comb begin
        cycle_next   = cycle_reg + CNT_W'(1);
        instret_next = instret_reg + CNT_W'(retire);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_reg   <= '0;
            instret_reg <= '0;
        end else begin
            cycle_reg   <= cycle_next;
            instret_reg <= instret_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_mem_alu_result <= '0;
            ex_mem_store_data <= '0;
            ex_mem_rd         <= '0;
            ex_mem_funct3     <= '0;
            ex_mem_regwrite   <= 1'b0;
            ex_mem_memread    <= 1'b0;
            ex_mem_memwrite   <= 1'b0;
            ex_mem_memtoreg   <= 1'b0;
        end else if (!DM_busy) begin
            ex_mem_alu_result <= result;
            ex_mem_store_data <= rs2_fwd;
            ex_mem_rd         <= id_ex_rd;
            ex_mem_funct3     <= id_ex_funct3;
            ex_mem_regwrite   <= id_ex_regwrite;
            ex_mem_memread    <= id_ex_memread;
            ex_mem_memwrite   <= id_ex_memwrite;
            ex_mem_memtoreg   <= id_ex_memtoreg;
        end
    end
endmodule
